// File: rtl/pll_supervisor_pkg.sv
// Shared state encoding and sizing helpers
// for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    BYPASS
  } state_t;

  localparam int LOSS_W = 8;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_supervisor_sync_2ff.sv
// Two-flop synchronizer for a single
// asynchronous level, resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_supervisor.sv
// PLL bring-up sequencer: qualifies lock,
// gates sys_clk reset, falls back to bypass.
module pll_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  localparam int RW = $clog2(MAX_RETRIES + 1),
  localparam int CW = $clog2(max3(RESET_CYCLES,
                                  LOCK_TIMEOUT,
                                  STABLE_CYCLES))
) (
  input  logic              ext_clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              relock_req,
  output logic              pll_resetb,
  output logic              pll_bypass,
  output logic              sys_rst_n,
  output logic              ready,
  output logic              fault,
  output logic [RW-1:0]     retry_count,
  output logic [LOSS_W-1:0] loss_count
);

  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRIES);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lock_s;
  logic          fail;

  sync_2ff u_sync (
    .clk   (ext_clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Timeout while waiting, or any drop while qualifying.
  always_comb begin
    fail = 1'b0;
    if (state == WAIT_LOCK && !lock_s && cnt == TO_LAST)
      fail = 1'b1;
    if (state == STABILIZE && !lock_s)
      fail = 1'b1;
  end

  always_ff @(posedge ext_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RESET_PLL;
      cnt         <= '0;
      pll_resetb  <= 1'b0;
      pll_bypass  <= 1'b0;
      sys_rst_n   <= 1'b0;
      ready       <= 1'b0;
      fault       <= 1'b0;
      retry_count <= '0;
      loss_count  <= '0;
    end else if (fail) begin
      cnt        <= '0;
      pll_resetb <= 1'b0;
      sys_rst_n  <= 1'b0;
      ready      <= 1'b0;
      if (retry_count == RTY_MAX) begin
        state      <= BYPASS;
        pll_bypass <= 1'b1;
        fault      <= 1'b1;
      end else begin
        state       <= RESET_PLL;
        retry_count <= retry_count + 1'b1;
      end
    end else begin
      unique case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            pll_resetb <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABILIZE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABILIZE: begin
          if (cnt == STB_LAST) begin
            state       <= RUN;
            cnt         <= '0;
            sys_rst_n   <= 1'b1;
            ready       <= 1'b1;
            retry_count <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s || relock_req) begin
            state      <= RESET_PLL;
            cnt        <= '0;
            pll_resetb <= 1'b0;
            sys_rst_n  <= 1'b0;
            ready      <= 1'b0;
            if (!lock_s && loss_count != '1)
              loss_count <= loss_count + 1'b1;
          end
        end
        BYPASS: begin
          if (relock_req) begin
            state       <= RESET_PLL;
            cnt         <= '0;
            pll_bypass  <= 1'b0;
            fault       <= 1'b0;
            retry_count <= '0;
            sys_rst_n   <= 1'b0;
          end else if (cnt == RST_LAST) begin
            sys_rst_n <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RESET_PLL;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
